// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg: shared state encodings and helpers for the acquisition
// sequencer. The state encoding is also what the `state` output reports, so the
// values below are part of the external interface (IDLE=0 ... FAULT=6).
package acq_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_TRIGGER   = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HOLDOFF   = 3'd5,
        ST_FAULT     = 3'd6
    } acq_state_e;

    // States in which a frame has been triggered and not yet completed.
    function automatic logic frame_in_flight(acq_state_e s);
        return (s == ST_TRIGGER) || (s == ST_WAIT_ACK) || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/acq_period_timer.sv
// acq_period_timer: frame-period down-counter.
//   clk, rst      : clock, synchronous active-high reset (counter -> 0)
//   load/load_val : load the counter (wins over enable)
//   en            : decrement by one per cycle while non-zero
//   zero          : counter currently reads 0 (period has expired)
//   near          : counter reads 1, i.e. it reaches 0 at the end of this cycle
module acq_period_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         near
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);
    assign near = (cnt_q == W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: frame acquisition sequencer driving an image transmitter.
//   cmd_start/cmd_stop/cmd_single : one-cycle commands; cmd_single sampled with cmd_start
//   frame_period / num_frames     : trigger spacing (0 treated as 1) / frame limit (0 = unlimited)
//   tx_busy / tx_in_progress      : transmitter config-intake busy / frame active
//   start_transmit                : one-cycle trigger; frame_done: one-cycle completion pulse
//   running, frame_count, overrun (sticky), fault, state (current encoding)
// Optional feature: define WATCHDOG_EN to add a WDOG_CYC-cycle watchdog over
// WAIT_ACK+WAIT_DONE that parks the sequencer in FAULT until cmd_stop.
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int FCNT_W   = 16,
    parameter int WDOG_CYC = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_single,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic [FCNT_W-1:0]   num_frames,
    input  logic                tx_busy,
    input  logic                tx_in_progress,
    output logic                start_transmit,
    output logic                running,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_count,
    output logic                overrun,
    output logic                fault,
    output logic [2:0]          state
);

    acq_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] period_q;
    logic [FCNT_W-1:0]   limit_q, count_q, count_inc;
    logic                single_q, overrun_q, stop_pend_q;
    logic                tmr_load, tmr_en, tmr_zero, tmr_near;
    logic                set_overrun, last_frame, wd_hit;

    acq_period_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (period_q - PERIOD_W'(1)),
        .en       (tmr_en),
        .zero     (tmr_zero),
        .near     (tmr_near)
    );

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt_q <= '0;
        else if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE)
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        else
            wd_cnt_q <= '0;
    end

    // Fires on the WDOG_CYC-th cycle spent waiting on the transmitter.
    assign wd_hit = (wd_cnt_q == WD_W'(WDOG_CYC - 1));
    assign fault  = (state_q == ST_FAULT);
`else
    assign wd_hit = 1'b0;
    assign fault  = 1'b0;
`endif

    assign count_inc  = (&count_q) ? count_q : count_q + FCNT_W'(1);
    // A stop arriving on the completion cycle itself still ends the run.
    assign last_frame = single_q || stop_pend_q || cmd_stop ||
                        ((limit_q != '0) && (count_inc == limit_q));

    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        frame_done  = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            ST_IDLE:
                if (cmd_start && !tx_busy && !cmd_stop) state_d = ST_ARM;
            ST_ARM:
                state_d = cmd_stop ? ST_IDLE : ST_TRIGGER;
            ST_TRIGGER: begin
                tmr_load = 1'b1;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                tmr_en = 1'b1;
                if (wd_hit)              state_d = ST_FAULT;
                else if (tx_in_progress) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                tmr_en = 1'b1;
                if (wd_hit) begin
                    state_d = ST_FAULT;
                end else if (!tx_in_progress) begin
                    frame_done = 1'b1;
                    if (last_frame) begin
                        state_d = ST_IDLE;
                    end else if (tmr_zero) begin
                        // period already elapsed during the frame: late trigger
                        set_overrun = 1'b1;
                        state_d     = ST_TRIGGER;
                    end else if (tmr_near) begin
                        // expires this cycle: triggering next cycle is on time
                        state_d = ST_TRIGGER;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                tmr_en = 1'b1;
                // near = timer reaches 0 this cycle, keeping triggers exactly
                // frame_period cycles apart.
                if (cmd_stop)                  state_d = ST_IDLE;
                else if (tmr_zero || tmr_near) state_d = ST_TRIGGER;
            end
            ST_FAULT:
                if (cmd_stop) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            period_q    <= PERIOD_W'(1);
            limit_q     <= '0;
            single_q    <= 1'b0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_ARM)
                single_q <= cmd_single;
            if (state_q == ST_ARM) begin
                period_q  <= (frame_period == '0) ? PERIOD_W'(1) : frame_period;
                limit_q   <= num_frames;
                count_q   <= '0;
                overrun_q <= 1'b0;
            end
            if (frame_done)  count_q   <= count_inc;
            if (set_overrun) overrun_q <= 1'b1;
            if (state_d == ST_IDLE || state_q == ST_ARM)
                stop_pend_q <= 1'b0;
            else if (cmd_stop && frame_in_flight(state_q))
                stop_pend_q <= 1'b1;
        end
    end

    assign start_transmit = (state_q == ST_TRIGGER);
    assign running        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign frame_count    = count_q;
    assign overrun        = overrun_q;
    assign state          = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed scoreboard bench for acq_sequencer. Stimulus pushes
// the expected cycle of every start_transmit / frame_done pulse into queues; a
// monitor pops and compares whenever the DUT pulses. A small transmitter model
// answers each trigger by holding tx_in_progress high for tx_len cycles.
module tb_acq_sequencer;

    localparam int PW = 24;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0, cmd_stop = 1'b0, cmd_single = 1'b0;
    logic [PW-1:0] frame_period = '0;
    logic [FW-1:0] num_frames = '0;
    logic          tx_busy = 1'b0, tx_in_progress = 1'b0;
    logic          start_transmit, running, frame_done, overrun, fault;
    logic [FW-1:0] frame_count;
    logic [2:0]    state;

    acq_sequencer #(.PERIOD_W(PW), .FCNT_W(FW), .WDOG_CYC(64)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_single(cmd_single), .frame_period(frame_period), .num_frames(num_frames),
        .tx_busy(tx_busy), .tx_in_progress(tx_in_progress),
        .start_transmit(start_transmit), .running(running), .frame_done(frame_done),
        .frame_count(frame_count), .overrun(overrun), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int fcnt; } done_t;
    int    trig_q[$];
    done_t done_q[$];
    int    n_checks = 0, n_pass = 0;
    int    tx_len = 10;
    bit    tx_hang = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // transmitter model
    initial forever begin
        @(negedge clk);
        if (start_transmit && !tx_hang) begin
            @(posedge clk); #1 tx_in_progress = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1 tx_in_progress = 1'b0;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (start_transmit) begin
            if (trig_q.size() == 0) check("unexpected_trigger", cyc, -1);
            else check("trigger_cycle", cyc, trig_q.pop_front());
        end
        if (frame_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_frame_done", cyc, -1);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("frame_done_cycle", cyc, d.cyc);
                check("frame_done_count", int'(frame_count), d.fcnt);
            end
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic sample_at(input int c);
        at_cycle(c);
        @(negedge clk);
    endtask

    task automatic push_done(input int c, input int f);
        done_t d;
        d.cyc = c; d.fcnt = f;
        done_q.push_back(d);
    endtask

    // First trigger lands two cycles after the start cycle (IDLE -> ARM -> TRIGGER).
    task automatic start_cmd(input bit single, input int period, input int nfr, output int t);
        int s;
        at_cycle(cyc + 1);
        s = cyc;
        cmd_start = 1'b1; cmd_single = single;
        frame_period = PW'(period); num_frames = FW'(nfr);
        at_cycle(s + 1);
        cmd_start = 1'b0; cmd_single = 1'b0;
        t = s + 2;
    endtask

    task automatic settle(input int c, input string tag);
        at_cycle(c);
        check({tag, "_pending_triggers"}, trig_q.size(), 0);
        check({tag, "_pending_dones"}, done_q.size(), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_start_transmit", int'(start_transmit), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_frame_count", int'(frame_count), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_running", int'(running), 0);

        // single shot, period 100, 20-cycle frame
        tx_len = 20;
        start_cmd(1'b1, 100, 0, t);
        trig_q.push_back(t); push_done(t + 21, 0);
        sample_at(t + 22);
        check("single_state", int'(state), 0);
        check("single_count", int'(frame_count), 1);
        check("single_overrun", int'(overrun), 0);
        settle(t + 130, "single");

        // continuous, 3 frames, period 50
        tx_len = 10;
        start_cmd(1'b0, 50, 3, t);
        for (int i = 0; i < 3; i++) begin
            trig_q.push_back(t + 50 * i);
            push_done(t + 50 * i + 11, i);
        end
        sample_at(t + 12);
        check("cont_holdoff_state", int'(state), 5);
        check("cont_running", int'(running), 1);
        sample_at(t + 112);
        check("cont_state", int'(state), 0);
        check("cont_count", int'(frame_count), 3);
        check("cont_overrun", int'(overrun), 0);
        settle(t + 170, "cont");

        // overrun: period 10, 30-cycle frame, 2 frames
        tx_len = 30;
        start_cmd(1'b0, 10, 2, t);
        trig_q.push_back(t); push_done(t + 31, 0);
        trig_q.push_back(t + 32); push_done(t + 63, 1);
        sample_at(t + 32);
        check("ovr_flag", int'(overrun), 1);
        sample_at(t + 64);
        check("ovr_end_state", int'(state), 0);
        check("ovr_end_count", int'(frame_count), 2);
        check("ovr_sticky", int'(overrun), 1);
        settle(t + 90, "ovr");

        // stop mid WAIT_DONE: frame completes, no further trigger
        tx_len = 20;
        start_cmd(1'b0, 50, 0, t);
        trig_q.push_back(t); push_done(t + 21, 0);
        at_cycle(t + 10); cmd_stop = 1'b1;
        at_cycle(t + 11); cmd_stop = 1'b0;
        sample_at(t + 22);
        check("stop_wd_state", int'(state), 0);
        check("stop_wd_count", int'(frame_count), 1);
        settle(t + 120, "stop_wd");

        // stop in HOLDOFF: IDLE on the next cycle
        tx_len = 10;
        start_cmd(1'b0, 50, 0, t);
        trig_q.push_back(t); push_done(t + 11, 0);
        at_cycle(t + 20); cmd_stop = 1'b1;
        @(negedge clk);
        check("stop_ho_before", int'(state), 5);
        at_cycle(t + 21); cmd_stop = 1'b0;
        @(negedge clk);
        check("stop_ho_state", int'(state), 0);
        settle(t + 90, "stop_ho");

        // reset in HOLDOFF overrides the run
        start_cmd(1'b0, 50, 0, t);
        trig_q.push_back(t); push_done(t + 11, 0);
        at_cycle(t + 15); rst = 1'b1;
        at_cycle(t + 16); rst = 1'b0;
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_count", int'(frame_count), 0);
        check("rst_running", int'(running), 0);
        settle(t + 90, "rst");

        // start while tx_busy, and start together with stop: both ignored
        at_cycle(cyc + 1);
        tx_busy = 1'b1; cmd_start = 1'b1;
        at_cycle(cyc + 1); cmd_start = 1'b0; tx_busy = 1'b0;
        @(negedge clk);
        check("busy_ignore_state", int'(state), 0);
        at_cycle(cyc + 1);
        cmd_start = 1'b1; cmd_stop = 1'b1;
        at_cycle(cyc + 1); cmd_start = 1'b0; cmd_stop = 1'b0;
        @(negedge clk);
        check("startstop_state", int'(state), 0);
        settle(cyc + 20, "ignore");

`ifdef WATCHDOG_EN
        // transmitter never acknowledges
        tx_hang = 1'b1;
        start_cmd(1'b1, 100, 0, t);
        trig_q.push_back(t);
        sample_at(t + 64);
        check("wdog_before_state", int'(state), 3);
        check("wdog_before_fault", int'(fault), 0);
        sample_at(t + 65);
        check("wdog_state", int'(state), 6);
        check("wdog_fault", int'(fault), 1);
        check("wdog_running", int'(running), 0);
        at_cycle(t + 70); cmd_stop = 1'b1;
        at_cycle(t + 71); cmd_stop = 1'b0;
        @(negedge clk);
        check("wdog_clear_state", int'(state), 0);
        check("wdog_clear_fault", int'(fault), 0);
        tx_hang = 1'b0;
        settle(t + 90, "wdog");
`else
        check("no_wdog_fault", int'(fault), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: cycle %0d exceeded time limit", cyc);
        $fatal(1, "timeout");
    end

endmodule
